// File: rtl/wrr_arbiter.sv
// wrr_arbiter
//   N-input weighted round-robin arbiter sharing one 32-bit stream sink.
//   Each requester keeps the grant for up to i_weight[k] consecutive beats
//   (0 treated as 1) before the grant rotates to the next valid requester.
//   One registered output stage; selection and transfer share a cycle, so an
//   owner switch costs no bubble.
//
// Optional feature: define WRR_PKT_LOCK_EN to hold the grant until the
//   owner's packet ends (i_req_last), stalling while the owner is not valid.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_req_data   N*DATA_W requester data, requester k at [k*DATA_W +: DATA_W]
//   i_req_valid  N requester valid
//   i_req_last   N end-of-packet markers (only used with WRR_PKT_LOCK_EN)
//   o_req_ready  N requester ready, one-hot or zero
//   i_weight     N*WEIGHT_W beats per turn, requester k at [k*WEIGHT_W +: WEIGHT_W]
//   o_x_data     registered arbitrated data
//   o_x_valid    registered arbitrated valid
//   o_x_src      registered index of the requester that supplied o_x_data
//   i_x_ready    downstream ready
module wrr_arbiter #(
  parameter int N        = 4,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N*DATA_W-1:0]    i_req_data,
  input  logic [N-1:0]           i_req_valid,
  input  logic [N-1:0]           i_req_last,
  output logic [N-1:0]           o_req_ready,
  input  logic [N*WEIGHT_W-1:0]  i_weight,
  output logic [DATA_W-1:0]      o_x_data,
  output logic                   o_x_valid,
  output logic [$clog2(N)-1:0]   o_x_src,
  input  logic                   i_x_ready
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0]    owner;
  logic [WEIGHT_W-1:0] credit;

  logic                slot_free;
  logic                search_hit;
  logic [IDX_W-1:0]    search_idx;
  logic [WEIGHT_W-1:0] search_w;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;
  logic [WEIGHT_W-1:0] credit_nxt;
  logic                pkt_hold;

`ifdef WRR_PKT_LOCK_EN
  logic in_pkt;
  assign pkt_hold = in_pkt;
`else
  logic unused_last;
  assign pkt_hold    = 1'b0;
  assign unused_last = ^i_req_last;
`endif

  assign slot_free = !o_x_valid || i_x_ready;

  // Rotating search: owner+1 .. owner+N (mod N), so the current owner is
  // considered last and a lone valid requester is re-selected with a reload.
  always_comb begin
    int unsigned idx;
    search_hit = 1'b0;
    search_idx = owner;
    idx        = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(owner) + i) % N;
      if (!search_hit && i_req_valid[idx]) begin
        search_hit = 1'b1;
        search_idx = IDX_W'(idx);
      end
    end
    search_w = i_weight[32'(search_idx)*WEIGHT_W +: WEIGHT_W];
  end

  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = owner;
    credit_nxt = credit;
    if (pkt_hold) begin
      // Packet lock: only the owner may continue; credit saturates at zero.
      if (i_req_valid[owner]) begin
        grant_vld  = 1'b1;
        credit_nxt = (credit == '0) ? '0 : credit - 1'b1;
      end
    end else if (i_req_valid[owner] && (credit != '0)) begin
      grant_vld  = 1'b1;
      credit_nxt = credit - 1'b1;
    end else if (search_hit) begin
      grant_vld  = 1'b1;
      grant_idx  = search_idx;
      credit_nxt = (search_w == '0) ? '0 : search_w - 1'b1;
    end
  end

  // Every grant goes to a valid requester, so ready implies a handshake.
  always_comb begin
    o_req_ready = '0;
    if (slot_free && grant_vld && !i_rst) begin
      o_req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner     <= IDX_W'(N - 1);
      credit    <= '0;
      o_x_valid <= 1'b0;
      o_x_data  <= '0;
      o_x_src   <= '0;
    end else if (slot_free) begin
      if (grant_vld) begin
        owner     <= grant_idx;
        credit    <= credit_nxt;
        o_x_valid <= 1'b1;
        o_x_data  <= i_req_data[32'(grant_idx)*DATA_W +: DATA_W];
        o_x_src   <= grant_idx;
      end else begin
        o_x_valid <= 1'b0;
      end
    end
  end

`ifdef WRR_PKT_LOCK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_pkt <= 1'b0;
    end else if (slot_free && grant_vld) begin
      in_pkt <= !i_req_last[grant_idx];
    end
  end
`endif

endmodule
